// File: rtl/z16_mmio_pkg.sv
// Shared Z16 MMIO constants, UART status layout and TX FSM state encoding.
package z16_mmio_pkg;

  localparam logic [15:0] MMIO_UART_STAT = 16'h0076;
  localparam logic [15:0] MMIO_UART_TX   = 16'h0078;
  localparam logic [15:0] MMIO_LED       = 16'h007A;
  localparam logic [15:0] MMIO_BTN       = 16'h007C;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_FULL = 1;
  localparam int unsigned STAT_OVF  = 2;

  typedef struct packed {
    logic [12:0] rsvd;
    logic        ovf;
    logic        full;
    logic        busy;
  } uart_status_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_tx_state_e;

endpackage

// File: rtl/z16_uart_tx_fifo.sv
// UART TX byte queue: circular buffer with Z16_UART_FIFO_EN, else one holding register.
module z16_uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

`ifdef Z16_UART_FIFO_EN
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // Pointers wrap explicitly so non-trivial depths stay in range.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (i_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  assign o_data  = mem[rd_ptr];
  assign o_full  = (count == CNT_W'(DEPTH));
  assign o_empty = (count == '0);
`else
  logic [7:0] hold;
  logic       valid;
  logic       unused_depth;

  // A push in the same cycle as a pop refills the register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid <= 1'b0;
    end else if (i_push) begin
      valid <= 1'b1;
    end else if (i_pop) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      hold <= i_data;
    end
  end

  assign o_data       = hold;
  assign o_full       = valid;
  assign o_empty      = ~valid;
  assign unused_depth = ^32'(DEPTH);
`endif

endmodule

// File: rtl/z16_mmio_uart_tx.sv
// Z16 MMIO UART transmitter (8N1): TXDATA at 0x0078, STATUS at 0x0076.
// Define Z16_UART_FIFO_EN for a FIFO_DEPTH-entry queue instead of one holding register.
module z16_mmio_uart_tx
  import z16_mmio_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 27_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_addr,
  input  logic        i_wen,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_hit,
  output logic        o_tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);

  uart_tx_state_e state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;

  logic       sel_stat_c, sel_tx_c, wr_tx_c, push_c, pop_c;
  logic       ovf_set_c, ovf_clr_c, baud_last_c;
  logic [7:0] fifo_data;
  logic       fifo_full, fifo_empty;
  logic       unused_wdata;
  uart_status_t status_c;

  z16_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_c),
    .i_data  (i_wdata[7:0]),
    .i_pop   (pop_c),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Register decode and zero-latency read path for the CPU load mux.
  always_comb begin
    sel_stat_c    = (i_addr == MMIO_UART_STAT);
    sel_tx_c      = (i_addr == MMIO_UART_TX);
    status_c      = '0;
    status_c.busy = (state_q != ST_IDLE) || !fifo_empty;
    status_c.full = fifo_full;
    status_c.ovf  = ovf_q;
    o_hit         = sel_stat_c || sel_tx_c;
    o_rdata       = sel_stat_c ? status_c : 16'h0000;
  end

  // A write to a full queue still lands if the FSM pops in the same cycle.
  always_comb begin
    wr_tx_c   = i_wen && sel_tx_c;
    push_c    = wr_tx_c && (!fifo_full || pop_c);
    ovf_set_c = wr_tx_c && fifo_full && !pop_c;
    ovf_clr_c = i_wen && sel_stat_c && i_wdata[STAT_OVF];
    ovf_d     = ovf_set_c ? 1'b1 : (ovf_clr_c ? 1'b0 : ovf_q);
  end

  assign baud_last_c  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign unused_wdata = ^i_wdata[15:8];

  // Frame sequencing; the STOP-to-START hop keeps queued frames back-to-back.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_data;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last_c) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_last_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (baud_last_c) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = fifo_data;
            bit_d   = '0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_tx = tx_q;

endmodule

// File: tb/tb_z16_mmio_uart_tx.sv
// Scoreboard bench for z16_mmio_uart_tx at 4 clocks per bit; builds with or without Z16_UART_FIFO_EN.
module tb_z16_mmio_uart_tx;
  import z16_mmio_pkg::*;

`ifdef Z16_UART_FIFO_EN
  localparam int CAP   = 5;
  localparam int N_B2B = 3;
`else
  localparam int CAP   = 2;
  localparam int N_B2B = 2;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_wen = 1'b0;
  logic [15:0] i_addr = 16'h0000;
  logic [15:0] i_wdata = 16'h0000;
  logic [15:0] o_rdata;
  logic        o_hit;
  logic        o_tx;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int aborted = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  z16_mmio_uart_tx #(
    .CLK_HZ     (1_000_000),
    .BAUD       (250_000),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_addr  (i_addr),
    .i_wen   (i_wen),
    .i_wdata (i_wdata),
    .o_rdata (o_rdata),
    .o_hit   (o_hit),
    .o_tx    (o_tx)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    @(negedge i_clk);
    i_addr  = a;
    i_wdata = d;
    i_wen   = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_wen   = 1'b0;
      i_addr  = 16'h0000;
      i_wdata = 16'h0000;
    end
  endtask

  task automatic read_stat(output logic [15:0] v);
    @(negedge i_clk);
    i_wen  = 1'b0;
    i_addr = MMIO_UART_STAT;
    #1;
    v = o_rdata;
  endtask

  task automatic wait_idle(input string name);
    logic [15:0] s;
    int n;
    n = 0;
    do begin
      read_stat(s);
      n++;
    end while (s[STAT_BUSY] && n < 400);
    check(name, 32'(s[STAT_BUSY]), 0);
  endtask

  // Monitor: decode each frame at mid-bit and compare against the scoreboard queue.
  initial begin
    logic [7:0] data;
    logic sb, stp, abort;
    forever begin
      @(posedge i_clk); #1;
      if (i_rst || o_tx !== 1'b0) continue;
      starts.push_back(cyc);
      abort = 1'b0;
      data  = 8'h00;
      sb    = 1'b1;
      stp   = 1'b0;
      for (int s = 1; s <= 39 && !abort; s++) begin
        @(posedge i_clk); #1;
        if (i_rst) abort = 1'b1;
        else if (s == 2) sb = o_tx;
        else if (s >= 6 && s <= 34 && (s - 6) % 4 == 0) data[3'((s - 6) / 4)] = o_tx;
        else if (s == 38) stp = o_tx;
      end
      if (abort) begin
        aborted++;
      end else begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got 0x%0h want none", data);
        end else begin
          check("frame_data", 32'(data), 32'(exp_q.pop_front()));
        end
        check("frame_start", 32'(sb), 0);
        check("frame_stop", 32'(stp), 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] s;
    int lowcnt, nf;

    // Reset and decode
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    check("rst_tx", 32'(o_tx), 1);
    i_addr = MMIO_UART_STAT; #1;
    check("rst_stat", 32'(o_rdata), 0);
    check("hit_stat", 32'(o_hit), 1);
    i_addr = MMIO_LED; #1;
    check("hit_led", 32'(o_hit), 0);
    check("rdata_led", 32'(o_rdata), 0);
    i_addr = MMIO_UART_TX; #1;
    check("hit_tx", 32'(o_hit), 1);
    check("rdata_tx", 32'(o_rdata), 0);

    store(MMIO_LED, 16'h00FF);
    read_stat(s);
    check("ign_wr", 32'(s), 0);

    // Single byte: latency, busy window, frame length
    store(MMIO_UART_TX, 16'h0155);
    exp_q.push_back(8'h55);
    idle(1);
    check("lat_n", 32'(o_tx), 1);
    idle(1);
    check("lat_n1", 32'(o_tx), 0);
    idle(19);
    read_stat(s);
    check("busy_mid", 32'(s), 32'h0001);
    idle(18);
    read_stat(s);
    check("busy_last", 32'(s), 32'h0001);
    read_stat(s);
    check("busy_end", 32'(s), 32'h0000);

    // Back-to-back frames
    nf = starts.size();
    for (int i = 0; i < N_B2B; i++) begin
      store(MMIO_UART_TX, 16'(16'h0041 + i));
      exp_q.push_back(8'(8'h41 + i));
    end
    read_stat(s);
    check("b2b_ovf", 32'(s[STAT_OVF]), 0);
    wait_idle("b2b_idle");
    check("b2b_frames", 32'(starts.size() - nf), 32'(N_B2B));
    for (int i = 1; i < N_B2B; i++) begin
      check("b2b_gap", 32'(starts[nf + i] - starts[nf + i - 1]), 40);
    end

    // Overflow, clear, and clear followed by a dropped write
    for (int i = 0; i < CAP + 1; i++) begin
      store(MMIO_UART_TX, 16'(16'h0060 + i));
      if (i < CAP) exp_q.push_back(8'(8'h60 + i));
    end
    read_stat(s);
    check("ovf_set", 32'(s), 32'h0007);
    store(MMIO_UART_STAT, 16'h0004);
    read_stat(s);
    check("ovf_clr", 32'(s), 32'h0003);
    store(MMIO_UART_STAT, 16'h0004);
    store(MMIO_UART_TX, 16'h007F);
    read_stat(s);
    check("ovf_reset_after_clr", 32'(s), 32'h0007);
    store(MMIO_UART_STAT, 16'hFFFB);
    read_stat(s);
    check("ovf_keep", 32'(s), 32'h0007);
    store(MMIO_UART_STAT, 16'h0004);
    read_stat(s);
    check("ovf_clr2", 32'(s), 32'h0003);
    wait_idle("ovf_idle");

    // Reset during data bit 3 of 0xA5
    store(MMIO_UART_TX, 16'h00A5);
    idle(19);
    check("mid_bit3", 32'(o_tx), 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("rst_mid_tx", 32'(o_tx), 1);
    read_stat(s);
    check("rst_mid_stat", 32'(s), 0);
    nf = starts.size();
    lowcnt = 0;
    repeat (60) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1) lowcnt++;
    end
    check("rst_quiet", 32'(lowcnt), 0);
    check("rst_noframe", 32'(starts.size() - nf), 0);

    check("aborted", 32'(aborted), 1);
    check("exp_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
